// File: rtl/vga_draw_pkg.sv
// vga_draw_pkg: shared FSM states, mode codes and default screen geometry
// for the VGA rectangle drawer.
package vga_draw_pkg;
    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_e;
    localparam logic MODE_RECT    = 1'b0;
    localparam logic MODE_CLEAR   = 1'b1;
    localparam int   SCREEN_W_DEF = 160;
    localparam int   SCREEN_H_DEF = 120;
endpackage

// File: rtl/vga_scan_counter.sv
// vga_scan_counter: row-major 2-D col/row counter with loadable end limits
// and a combinational flag marking the final position.
module vga_scan_counter #(
    parameter int CW = 8,
    parameter int RW = 7
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load_i,
    input  logic          en_i,
    input  logic [CW-1:0] last_col_i,
    input  logic [RW-1:0] last_row_i,
    output logic [CW-1:0] col_o,
    output logic [RW-1:0] row_o,
    output logic          last_o
);
    logic [CW-1:0] col_q, col_d, last_col_q, last_col_d;
    logic [RW-1:0] row_q, row_d, last_row_q, last_row_d;
    logic          col_end, row_end;
    always_comb begin
        col_end    = col_q == last_col_q;
        row_end    = row_q == last_row_q;
        last_col_d = load_i ? last_col_i : last_col_q;
        last_row_d = load_i ? last_row_i : last_row_q;
        col_d      = (load_i || (en_i && col_end)) ? '0 : en_i ? col_q + 1'b1 : col_q;
        row_d      = (load_i || (en_i && col_end && row_end)) ? '0 :
                     (en_i && col_end) ? row_q + 1'b1 : row_q;
    end
    // Wrapping back to 0 at the end leaves the outputs sitting on the base in IDLE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            col_q      <= '0;
            row_q      <= '0;
            last_col_q <= '0;
            last_row_q <= '0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            last_col_q <= last_col_d;
            last_row_q <= last_row_d;
        end
    end
    assign col_o  = col_q;
    assign row_o  = row_q;
    assign last_o = col_end && row_end;
endmodule

// File: rtl/vga_rect_drawer.sv
// vga_rect_drawer: streams one pixel per clock of a filled box or full-screen clear
// to the 160x120 VGA adapter. Define VGA_RECT_CLIP_EN to suppress off-screen plots.
module vga_rect_drawer
    import vga_draw_pkg::*;
#(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3,
    parameter int SIZE_W   = 4,
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                mode,
    input  logic [X_W-1:0]      x_in,
    input  logic [Y_W-1:0]      y_in,
    input  logic [SIZE_W-1:0]   w_in,
    input  logic [SIZE_W-1:0]   h_in,
    input  logic [COLOUR_W-1:0] colour_in,
    output logic [X_W-1:0]      x_out,
    output logic [Y_W-1:0]      y_out,
    output logic [COLOUR_W-1:0] colour_out,
    output logic                plot,
    output logic                busy,
    output logic                done
);
    state_e                state_q, state_d;
    logic [X_W-1:0]        base_x_q, base_x_d, col, last_col;
    logic [Y_W-1:0]        base_y_q, base_y_d, row, last_row;
    logic [COLOUR_W-1:0]   colour_q, colour_d;
    logic                  load, en, last;
    logic                  clear;
    always_comb begin
        clear    = mode == MODE_CLEAR;
        load     = state_q == IDLE && start;
        en       = state_q == DRAW;
        state_d  = load ? DRAW : (en && last) ? DONE : (state_q == DONE) ? IDLE : state_q;
        base_x_d = load ? (clear ? '0 : x_in) : base_x_q;
        base_y_d = load ? (clear ? '0 : y_in) : base_y_q;
        colour_d = load ? colour_in : colour_q;
        last_col = clear ? X_W'(SCREEN_W - 1) : X_W'(w_in);
        last_row = clear ? Y_W'(SCREEN_H - 1) : Y_W'(h_in);
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            base_x_q <= '0;
            base_y_q <= '0;
            colour_q <= '0;
        end else begin
            state_q  <= state_d;
            base_x_q <= base_x_d;
            base_y_q <= base_y_d;
            colour_q <= colour_d;
        end
    end
    vga_scan_counter #(.CW(X_W), .RW(Y_W)) u_scan (
        .clock      (clock),
        .reset      (reset),
        .load_i     (load),
        .en_i       (en),
        .last_col_i (last_col),
        .last_row_i (last_row),
        .col_o      (col),
        .row_o      (row),
        .last_o     (last)
    );
`ifdef VGA_RECT_CLIP_EN
    // One extra bit so a sum that wraps the coordinate width still reads as off-screen.
    logic [X_W:0] x_sum;
    logic [Y_W:0] y_sum;
    assign x_sum = {1'b0, base_x_q} + {1'b0, col};
    assign y_sum = {1'b0, base_y_q} + {1'b0, row};
    assign x_out = x_sum[X_W-1:0];
    assign y_out = y_sum[Y_W-1:0];
    assign plot  = en && x_sum < (X_W+1)'(SCREEN_W) && y_sum < (Y_W+1)'(SCREEN_H);
`else
    assign x_out = base_x_q + col;
    assign y_out = base_y_q + row;
    assign plot  = en;
`endif
    assign colour_out = colour_q;
    assign busy       = state_q != IDLE;
    assign done       = state_q == DONE;
endmodule

// File: tb/tb_vga_rect_drawer.sv
// tb_vga_rect_drawer: table-driven checks of box/clear drawing plus hand sequences
// for ignored restarts, start during DONE and asynchronous reset mid-draw.
module tb_vga_rect_drawer;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       mode  = 1'b0;
    logic [7:0] x_in  = '0;
    logic [6:0] y_in  = '0;
    logic [3:0] w_in  = '0;
    logic [3:0] h_in  = '0;
    logic [2:0] colour_in = '0;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour_out;
    logic       plot, busy, done;
    int         total  = 0;
    int         passed = 0;

    typedef struct {
        logic       m;
        logic [7:0] x;
        logic [6:0] y;
        logic [3:0] w;
        logic [3:0] h;
        logic [2:0] c;
        int         n;
        int         ix;
        int         iy;
    } vec_t;
    vec_t v[5];

    vga_rect_drawer dut (
        .clock(clock), .reset(reset), .start(start), .mode(mode),
        .x_in(x_in), .y_in(y_in), .w_in(w_in), .h_in(h_in), .colour_in(colour_in),
        .x_out(x_out), .y_out(y_out), .colour_out(colour_out),
        .plot(plot), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Called at a negedge in IDLE; walks every DRAW cycle against the row-major model.
    task automatic run_op(input logic m, input logic [7:0] x, input logic [6:0] y,
                          input logic [3:0] w, input logic [3:0] h, input logic [2:0] c,
                          input int n, input int ix, input int iy, input int inj,
                          input bit start_at_done, input string nm);
        int bx, by, wl, errs, cc, rr, ex, ey, ep;
        mode = m; x_in = x; y_in = y; w_in = w; h_in = h; colour_in = c; start = 1'b1;
        bx = m ? 0 : int'(x);
        by = m ? 0 : int'(y);
        wl = m ? 159 : int'(w);
        errs = 0;
        @(negedge clock);
        for (int k = 0; k < n; k++) begin
            cc = k % (wl + 1);
            rr = k / (wl + 1);
            ex = (bx + cc) % 256;
            ey = (by + rr) % 128;
`ifdef VGA_RECT_CLIP_EN
            ep = (bx + cc < 160 && by + rr < 120) ? 1 : 0;
`else
            ep = 1;
`endif
            if (busy !== 1'b1 || int'(plot) != ep || int'(x_out) != ex ||
                int'(y_out) != ey || colour_out !== c) begin
                if (errs < 3)
                    $display("FAIL %s_pix k=%0d: got x=%0d y=%0d c=%0d p=%0d b=%0d expected x=%0d y=%0d c=%0d p=%0d",
                             nm, k, x_out, y_out, colour_out, plot, busy, ex, ey, c, ep);
                errs++;
            end
            if (k == 0) begin
                start = 1'b0; x_in = ~x; y_in = ~y; w_in = ~w; h_in = ~h; colour_in = ~c; mode = ~m;
            end
            if (k == inj) begin
                start = 1'b1; mode = 1'b0; x_in = 8'd100; y_in = 7'd50; w_in = 4'd9; h_in = 4'd9; colour_in = ~c;
            end
            if (k == inj + 1) start = 1'b0;
            @(negedge clock);
        end
        chk({nm, "_pix_errs"}, errs, 0);
        chk({nm, "_done_cyc"}, int'({done, plot, busy}), 3'b101);
        if (start_at_done) begin
            start = 1'b1; mode = 1'b0; x_in = 8'd7; y_in = 7'd7; w_in = 4'd1; h_in = 4'd1;
        end
        @(negedge clock);
        start = 1'b0;
        chk({nm, "_idle_flags"}, int'({done, plot, busy}), 0);
        chk({nm, "_idle_x"}, int'(x_out), ix);
        chk({nm, "_idle_y"}, int'(y_out), iy);
    endtask

    initial begin
        int seen;
        v[0] = '{1'b0, 8'd10,  7'd20,  4'd3,  4'd1,  3'd5, 8,     10,  20};
        v[1] = '{1'b0, 8'd0,   7'd0,   4'd0,  4'd0,  3'd2, 1,     0,   0};
        v[2] = '{1'b0, 8'd158, 7'd118, 4'd3,  4'd3,  3'd7, 16,    158, 118};
        v[3] = '{1'b1, 8'd33,  7'd44,  4'd5,  4'd6,  3'd0, 19200, 0,   0};
        v[4] = '{1'b0, 8'd250, 7'd100, 4'd15, 4'd15, 3'd6, 256,   250, 100};

        #3;
        chk("reset_outputs", int'({x_out, y_out, colour_out, plot, busy, done}), 0);
        @(negedge clock);
        @(negedge clock);
        chk("reset_held", int'({x_out, y_out, colour_out, plot, busy, done}), 0);
        reset = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 5; i++)
            run_op(v[i].m, v[i].x, v[i].y, v[i].w, v[i].h, v[i].c,
                   v[i].n, v[i].ix, v[i].iy, -1, 1'b0, $sformatf("vec%0d", i));

        // Restart mid-draw is ignored; start during the DONE pulse is ignored too.
        run_op(1'b0, 8'd5, 7'd6, 4'd2, 4'd1, 3'd3, 6, 5, 6, 2, 1'b1, "restart");

        // Asynchronous reset in the middle of a draw.
        mode = 1'b0; x_in = 8'd1; y_in = 7'd2; w_in = 4'd7; h_in = 4'd7; colour_in = 3'd4; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        chk("pre_reset_draw", int'({plot, busy}), 2'b11);
        #2 reset = 1'b0;
        #1 chk("async_reset_drop", int'({plot, busy, done}), 0);
        seen = 0;
        repeat (3) begin
            @(negedge clock);
            if (done) seen++;
        end
        chk("reset_no_done", seen, 0);
        chk("reset_base_cleared", int'({x_out, y_out}), 0);
        reset = 1'b1;
        @(negedge clock);
        run_op(1'b0, 8'd40, 7'd30, 4'd1, 4'd2, 3'd1, 6, 40, 30, -1, 1'b0, "after_reset");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
